// File: rtl/wf_issue_arb_8.sv
// wf_issue_arb_8: 8-slot round-robin issue arbiter with a registered grant.
// A grant is offered until the downstream stage accepts it. On accept, the next
// grant is picked in the same cycle, so back-to-back grants have no bubble.
module wf_issue_arb_8 #(
    parameter logic [2:0] PTR_INIT = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] request,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_sel,
    output logic       busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_sel;
    logic       r_valid;

    state_t     w_next_state;
    logic [2:0] w_next_ptr;
    logic [2:0] w_next_sel;
    logic       w_accept;
    logic [7:0] w_elig;
    logic [2:0] w_start;
    logic [3:0] w_pick;

    // Round-robin search: first set bit of vec, scanning start, start+1, ... (mod 8).
    // Result bit 3 flags that a bit was found; bits 2:0 hold its index.
    function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int k = 7; k >= 0; k--) begin
            idx = start + k[2:0];
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Select the vector to arbitrate over and where the search starts.
    always_comb begin
        w_accept = 1'b0;
        w_elig   = 8'h00;
        w_start  = r_ptr;
        case (r_state)
            ST_IDLE: begin
                w_elig  = request;
                w_start = r_ptr;
            end
            ST_OFFER: begin
                if (out_ready) begin
                    // The slot just accepted is excluded so the next grant moves on.
                    w_accept = 1'b1;
                    w_elig   = request & ~(8'h01 << r_sel);
                    w_start  = r_sel + 3'd1;
                end else begin
                    w_accept = 1'b0;
                    w_elig   = 8'h00;
                    w_start  = r_ptr;
                end
            end
            default: begin
                w_accept = 1'b0;
                w_elig   = 8'h00;
                w_start  = r_ptr;
            end
        endcase
    end

    assign w_pick = rr_pick(w_elig, w_start);

    // Next-state, next-grant and pointer update.
    always_comb begin
        w_next_state = r_state;
        w_next_sel   = r_sel;
        w_next_ptr   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick[3]) begin
                    w_next_state = ST_OFFER;
                    w_next_sel   = w_pick[2:0];
                end else begin
                    w_next_state = ST_IDLE;
                    w_next_sel   = r_sel;
                end
            end
            ST_OFFER: begin
                if (w_accept) begin
                    w_next_ptr = r_sel + 3'd1;
                    if (w_pick[3]) begin
                        w_next_state = ST_OFFER;
                        w_next_sel   = w_pick[2:0];
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_sel   = r_sel;
                    end
                end else begin
                    // A held grant is never retracted, whatever request does.
                    w_next_state = ST_OFFER;
                    w_next_sel   = r_sel;
                    w_next_ptr   = r_ptr;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_sel   = r_sel;
                w_next_ptr   = r_ptr;
            end
        endcase
    end

    // State registers; a reset drops any held grant without advancing the pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_ptr   <= PTR_INIT;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_sel   <= w_next_sel;
            r_ptr   <= w_next_ptr;
            r_valid <= (w_next_state == ST_OFFER);
        end
    end

    assign out_valid = r_valid;
    assign busy      = r_valid;
    assign out_sel   = r_sel;

endmodule

// File: tb/tb_wf_issue_arb_8.sv
// Directed bench for wf_issue_arb_8: each step drives inputs, queues the
// expected post-edge outputs, then pops and checks them after the edge.
module tb_wf_issue_arb_8;

    logic       clk;
    logic       rst;
    logic [7:0] request;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_sel;
    logic       busy;

    typedef struct packed {
        logic       v;
        logic [2:0] s;
        logic       chk_sel;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;
    int    grant_cnt[8];

    wf_issue_arb_8 #(.PTR_INIT(3'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (out_valid === e.v) else begin
            errors++;
            $error("FAIL %s out_valid: got %0b expected %0b", t, out_valid, e.v);
        end
        checks++;
        assert (busy === e.v) else begin
            errors++;
            $error("FAIL %s busy: got %0b expected %0b", t, busy, e.v);
        end
        if (e.chk_sel) begin
            checks++;
            assert (out_sel === e.s) else begin
                errors++;
                $error("FAIL %s out_sel: got %0d expected %0d", t, out_sel, e.s);
            end
        end
    endtask

    task automatic step(input logic [7:0] req, input logic rdy, input logic rs,
                        input logic ev, input logic [2:0] es, input logic cs,
                        input string tag);
        exp_t e;
        request   = req;
        out_ready = rdy;
        rst       = rs;
        e.v       = ev;
        e.s       = es;
        e.chk_sel = cs;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        request   = 8'h00;
        out_ready = 1'b0;
        rst       = 1'b0;

        // Reset, then idle with no requests.
        step(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, "reset0");
        step(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, "reset1");
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, "idle_zero");

        // Two requesters with ready held: alternation without bubbles.
        step(8'h24, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, "alt_first2");
        step(8'h24, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, "alt_then5");
        step(8'h24, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, "alt_again2");
        step(8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, "alt_drain");

        // Grant on slot 7 held under backpressure, then wrap to slot 0 (ptr is 3 here).
        step(8'h80, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, "hold_grant7");
        for (int i = 0; i < 3; i++) step(8'h01, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, "hold_stable7");
        step(8'h01, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, "wrap_to0");
        step(8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, "wrap_drain");

        // Full request, 16 accepts: each slot in order, each exactly twice.
        step(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, "reset_ff");
        for (int i = 0; i < 8; i++) grant_cnt[i] = 0;
        for (int i = 0; i < 16; i++) begin
            step(8'hFF, 1'b1, 1'b1, 1'b1, i[2:0], 1'b1, "ff_seq");
            if (out_valid === 1'b1) grant_cnt[out_sel]++;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            assert (grant_cnt[i] == 2) else begin
                errors++;
                $error("FAIL ff_count slot %0d: got %0d expected 2", i, grant_cnt[i]);
            end
        end
        step(8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, "ff_drain");

        // Reset while offering slot 3: grant dropped, ptr back to 0 not 4.
        step(8'h04, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, "pre_rst_grant2");
        step(8'h08, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, "pre_rst_grant3");
        step(8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, "pre_rst_hold3");
        step(8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, "mid_reset");
        step(8'hFF, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, "post_rst_ptr0");
        step(8'hFF, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, "post_rst_next1");
        step(8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, "reset_again");
        step(8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, "regrant3");

        // Single request accepted, then idle; out_ready ignored; ptr becomes 5.
        step(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, "reset_single");
        step(8'h10, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, "single_grant4");
        step(8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, "single_accept");
        step(8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, "idle_ready_ignored");
        step(8'hFF, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, "ptr_is5");
        step(8'hFF, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, "ptr_next6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
